// File: rtl/bpsk_pkg.sv
// Shared types and sizing helpers for the transmitter byte-sorting path.
package bpsk_pkg;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_SORT,
    ST_OUT
  } state_t;

  localparam logic [7:0] DEFAULT_PREAMBLE = 8'hA5;

  function automatic int unsigned frame_width(input int unsigned packet_width,
                                              input int unsigned data_width,
                                              input int unsigned index_width,
                                              input int unsigned preamble_length);
    return packet_width * (data_width + index_width) + preamble_length;
  endfunction

endpackage

// File: rtl/sorter_sync_framer_cmp_swap.sv
// One odd-even transposition pass over the slot array; ties never swap.
module cmp_swap_stage #(
  parameter int unsigned PACKET_WIDTH = 8,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned INDEX_WIDTH  = $clog2(PACKET_WIDTH)
) (
  input  logic [PACKET_WIDTH-1:0][DATA_WIDTH+INDEX_WIDTH-1:0] slots_in,
  input  logic                                                odd_pass,
  input  logic                                                descending,
  output logic [PACKET_WIDTH-1:0][DATA_WIDTH+INDEX_WIDTH-1:0] slots_out
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]  data;
    logic [INDEX_WIDTH-1:0] idx;
  } slot_t;

  slot_t [PACKET_WIDTH-1:0] a;
  slot_t [PACKET_WIDTH-1:0] y;

  assign a         = slots_in;
  assign slots_out = y;

  // Pairs of one parity are disjoint, so every swap reads the unmodified input.
  always_comb begin
    y = a;
    for (int unsigned k = 0; k + 1 < PACKET_WIDTH; k++) begin
      if (k[0] == odd_pass) begin
        if (descending ? (a[k].data < a[k+1].data) : (a[k].data > a[k+1].data)) begin
          y[k]   = a[k+1];
          y[k+1] = a[k];
        end
      end
    end
  end

endmodule

// File: rtl/sorter_sync_framer.sv
// Streaming packet sorter: loads PACKET_WIDTH bytes, runs one transposition pass
// per cycle, then presents {indices, data, preamble} on a valid/ready output.
module sorter_sync_framer
  import bpsk_pkg::*;
#(
  parameter int unsigned PACKET_WIDTH    = 8,
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned INDEX_WIDTH     = $clog2(PACKET_WIDTH),
  parameter int unsigned PREAMBLE_LENGTH = 8,
  parameter logic [PREAMBLE_LENGTH-1:0] PREAMBLE = PREAMBLE_LENGTH'(DEFAULT_PREAMBLE),
  localparam int unsigned FRAME_WIDTH =
    frame_width(PACKET_WIDTH, DATA_WIDTH, INDEX_WIDTH, PREAMBLE_LENGTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_byte,
  input  logic                   descending,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [FRAME_WIDTH-1:0] frame_out,
  output logic                   busy
);

  localparam int unsigned      CNT_W = $clog2(PACKET_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(PACKET_WIDTH - 1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]  data;
    logic [INDEX_WIDTH-1:0] idx;
  } slot_t;

  state_t                   state;
  logic [CNT_W-1:0]         count;
  logic [CNT_W-1:0]         pass;
  logic                     desc_q;
  slot_t [PACKET_WIDTH-1:0] slots;
  slot_t [PACKET_WIDTH-1:0] slots_next;
  logic [INDEX_WIDTH-1:0]   load_idx;
  logic [FRAME_WIDTH-1:0]   frame_next;

  assign load_idx = count[INDEX_WIDTH-1:0];

  cmp_swap_stage #(
    .PACKET_WIDTH (PACKET_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH),
    .INDEX_WIDTH  (INDEX_WIDTH)
  ) u_stage (
    .slots_in   (slots),
    .odd_pass   (pass[0]),
    .descending (desc_q),
    .slots_out  (slots_next)
  );

  always_comb begin
    frame_next = '0;
    frame_next[PREAMBLE_LENGTH-1:0] = PREAMBLE;
    for (int unsigned k = 0; k < PACKET_WIDTH; k++) begin
      frame_next[PREAMBLE_LENGTH + k*DATA_WIDTH +: DATA_WIDTH] = slots[k].data;
      frame_next[PREAMBLE_LENGTH + PACKET_WIDTH*DATA_WIDTH + k*INDEX_WIDTH +: INDEX_WIDTH] =
        slots[k].idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_LOAD;
      count     <= '0;
      pass      <= '0;
      desc_q    <= 1'b0;
      slots     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      frame_out <= '0;
    end else begin
      unique case (state)
        ST_LOAD: begin
          if (in_valid && in_ready) begin
            slots[load_idx].data <= in_byte;
            slots[load_idx].idx  <= load_idx;
            if (count == '0) desc_q <= descending;
            count <= count + 1'b1;
            if (count == LAST) begin
              state    <= ST_SORT;
              pass     <= '0;
              in_ready <= 1'b0;
              busy     <= 1'b1;
            end
          end
        end
        ST_SORT: begin
          slots <= slots_next;
          pass  <= pass + 1'b1;
          if (pass == LAST) state <= ST_OUT;
        end
        // First OUT cycle registers the frame; this keeps frame_out off the sort path.
        ST_OUT: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            frame_out <= frame_next;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            count     <= '0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_LOAD;
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

endmodule
